// File: rtl/rtc_aou_counter.sv
// rtc_aou_counter: always-on RTC time base.
// Runs a prescaler and the current-count register (CCVR), and raises a match
// interrupt when CCVR equals match_val on a prescaler tick.
// Optional feature macro: RTC_AOU_ETB_MATCH_EN adds the rtc_etb_match output,
// a registered one-cycle pulse per match tick.
module rtc_aou_counter #(
  parameter int CNT_W = 32,
  parameter int DIV_W = 20
) (
  input  logic             pclk_gate,
  input  logic             presetn,
  input  logic             cnt_en,
  input  logic             wrap_en,
  input  logic             intr_en,
  input  logic             intr_mask,
  input  logic [CNT_W-1:0] match_val,
  input  logic [DIV_W-1:0] rtcclkdivcfg,
  input  logic             pdu_aou_wen_lr,
  input  logic [CNT_W-1:0] pwdata,
  input  logic             pdu_aou_eoi,
  output logic [CNT_W-1:0] aou_pdu_ccvr,
  output logic             aou_pdu_raw_intr,
  output logic             rtc_intr
`ifdef RTC_AOU_ETB_MATCH_EN
  ,
  output logic             rtc_etb_match
`endif
);

  logic [DIV_W-1:0] div_cnt_reg;
  logic [DIV_W-1:0] div_cnt_next;
  logic [CNT_W-1:0] ccvr_reg;
  logic [CNT_W-1:0] ccvr_next;
  logic             raw_stat_reg;
  logic             raw_stat_next;

  logic             div_bypass;
  logic             div_expired;
  logic             tick_raw;
  logic             tick;
  logic             match_hit;

  // Tick generation: divisors 0 and 1 tick every cycle; otherwise tick once the
  // count reaches divisor-1. Using >= lets a lowered divisor take effect on the
  // very next cycle instead of waiting for the counter to wrap its full width.
  // A load write always wins, so a same-cycle tick (and its match) is dropped.
  always_comb begin
    div_bypass  = (rtcclkdivcfg <= DIV_W'(1));
    div_expired = (div_cnt_reg >= (rtcclkdivcfg - DIV_W'(1)));
    tick_raw    = cnt_en & (div_bypass | div_expired);
    tick        = tick_raw & ~pdu_aou_wen_lr;
    match_hit   = tick & (ccvr_reg == match_val);
  end

  // Next-state for prescaler, count and raw status.
  always_comb begin
    // Prescaler holds at zero while disabled, so counting always starts from
    // a full period when cnt_en rises.
    div_cnt_next = div_cnt_reg + DIV_W'(1);
    if (pdu_aou_wen_lr || !cnt_en || tick_raw) begin
      div_cnt_next = '0;
    end

    // Count: load > tick (wrap-to-zero on match, else increment) > hold.
    // Increment wraps silently modulo 2^CNT_W.
    ccvr_next = ccvr_reg;
    if (pdu_aou_wen_lr) begin
      ccvr_next = pwdata;
    end else if (tick) begin
      if (match_hit && wrap_en) begin
        ccvr_next = '0;
      end else begin
        ccvr_next = ccvr_reg + CNT_W'(1);
      end
    end

    // Raw status: disabled interrupts clear it; a new match beats a same-cycle
    // end-of-interrupt so no event is lost.
    raw_stat_next = raw_stat_reg;
    if (!intr_en) begin
      raw_stat_next = 1'b0;
    end else if (match_hit) begin
      raw_stat_next = 1'b1;
    end else if (pdu_aou_eoi) begin
      raw_stat_next = 1'b0;
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge pclk_gate or negedge presetn) begin
    if (!presetn) begin
      div_cnt_reg  <= '0;
      ccvr_reg     <= '0;
      raw_stat_reg <= 1'b0;
    end else begin
      div_cnt_reg  <= div_cnt_next;
      ccvr_reg     <= ccvr_next;
      raw_stat_reg <= raw_stat_next;
    end
  end

`ifdef RTC_AOU_ETB_MATCH_EN
  logic etb_match_reg;

  // Match pulse for the ETB, independent of interrupt enable/mask and wrap.
  always_ff @(posedge pclk_gate or negedge presetn) begin
    if (!presetn) begin
      etb_match_reg <= 1'b0;
    end else begin
      etb_match_reg <= match_hit;
    end
  end

  assign rtc_etb_match = etb_match_reg;
`endif

  assign aou_pdu_ccvr     = ccvr_reg;
  assign aou_pdu_raw_intr = raw_stat_reg;
  assign rtc_intr         = raw_stat_reg & ~intr_mask;

endmodule

// File: tb/tb_rtc_aou_counter.sv
// Self-checking bench for rtc_aou_counter. Each scenario pushes the expected
// post-edge state to a scoreboard queue as it drives a cycle, then pops and
// compares once the edge has happened.
module tb_rtc_aou_counter;

  logic        pclk_gate = 1'b0;
  logic        presetn;
  logic        cnt_en;
  logic        wrap_en;
  logic        intr_en;
  logic        intr_mask;
  logic [31:0] match_val;
  logic [19:0] rtcclkdivcfg;
  logic        pdu_aou_wen_lr;
  logic [31:0] pwdata;
  logic        pdu_aou_eoi;
  logic [31:0] aou_pdu_ccvr;
  logic        aou_pdu_raw_intr;
  logic        rtc_intr;
`ifdef RTC_AOU_ETB_MATCH_EN
  logic        rtc_etb_match;
`endif

  typedef struct {
    string       tag;
    logic [31:0] ccvr;
    logic        raw;
    logic        intr;
    logic        etb;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  rtc_aou_counter dut (
    .pclk_gate        (pclk_gate),
    .presetn          (presetn),
    .cnt_en           (cnt_en),
    .wrap_en          (wrap_en),
    .intr_en          (intr_en),
    .intr_mask        (intr_mask),
    .match_val        (match_val),
    .rtcclkdivcfg     (rtcclkdivcfg),
    .pdu_aou_wen_lr   (pdu_aou_wen_lr),
    .pwdata           (pwdata),
    .pdu_aou_eoi      (pdu_aou_eoi),
    .aou_pdu_ccvr     (aou_pdu_ccvr),
    .aou_pdu_raw_intr (aou_pdu_raw_intr),
    .rtc_intr         (rtc_intr)
`ifdef RTC_AOU_ETB_MATCH_EN
    ,
    .rtc_etb_match    (rtc_etb_match)
`endif
  );

  always #5 pclk_gate = ~pclk_gate;

  // Reset held, then released with the counter disabled.
  task automatic test_reset();
    exp_t e;
    for (int i = 0; i < 2; i++) begin
      sb.push_back('{"reset", 32'd0, 1'b0, 1'b0, 1'b0});
      if (i == 0) begin
        repeat (2) @(posedge pclk_gate);
        #1;
      end else begin
        @(negedge pclk_gate);
        presetn = 1'b1;
        @(posedge pclk_gate);
        #1;
      end
      e = sb.pop_front();
      checks++;
      if ({aou_pdu_ccvr, aou_pdu_raw_intr, rtc_intr} !== {e.ccvr, e.raw, e.intr}) begin
        errors++;
        $display("FAIL %s[%0d] got ccvr=%h raw=%b intr=%b, exp ccvr=%h raw=%b intr=%b",
                 e.tag, i, aou_pdu_ccvr, aou_pdu_raw_intr, rtc_intr, e.ccvr, e.raw, e.intr);
      end else begin
        $display("ok   %s[%0d] ccvr=%h raw=%b intr=%b", e.tag, i, aou_pdu_ccvr, aou_pdu_raw_intr, rtc_intr);
      end
`ifdef RTC_AOU_ETB_MATCH_EN
      checks++;
      if (rtc_etb_match !== e.etb) begin
        errors++;
        $display("FAIL %s[%0d] etb got %b exp %b", e.tag, i, rtc_etb_match, e.etb);
      end
`endif
    end
  endtask

  // Divisor 1, then 0 (every cycle), then 4 (every 4th cycle), then freeze.
  task automatic test_prescale();
    exp_t        e;
    logic [31:0] tab [23];
    tab = '{32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd6,
            32'd7, 32'd8, 32'd9, 32'd10, 32'd11, 32'd12,
            32'd12, 32'd12, 32'd12, 32'd13, 32'd13, 32'd13, 32'd13, 32'd14,
            32'd14, 32'd14, 32'd14};
    match_val = 32'hFFFF_0000;
    intr_en   = 1'b0;
    wrap_en   = 1'b0;
    for (int i = 0; i < 23; i++) begin
      cnt_en       = (i < 20);
      rtcclkdivcfg = (i < 6) ? 20'd1 : (i < 12) ? 20'd0 : 20'd4;
      sb.push_back('{"prescale", tab[i], 1'b0, 1'b0, 1'b0});
      @(posedge pclk_gate);
      #1;
      e = sb.pop_front();
      checks++;
      if ({aou_pdu_ccvr, aou_pdu_raw_intr, rtc_intr} !== {e.ccvr, e.raw, e.intr}) begin
        errors++;
        $display("FAIL %s[%0d] got ccvr=%h raw=%b intr=%b, exp ccvr=%h raw=%b intr=%b",
                 e.tag, i, aou_pdu_ccvr, aou_pdu_raw_intr, rtc_intr, e.ccvr, e.raw, e.intr);
      end else begin
        $display("ok   %s[%0d] ccvr=%h raw=%b intr=%b", e.tag, i, aou_pdu_ccvr, aou_pdu_raw_intr, rtc_intr);
      end
`ifdef RTC_AOU_ETB_MATCH_EN
      checks++;
      if (rtc_etb_match !== e.etb) begin
        errors++;
        $display("FAIL %s[%0d] etb got %b exp %b", e.tag, i, rtc_etb_match, e.etb);
      end
`endif
    end
  endtask

  // Load beats a same-cycle tick; afterwards divisor 3 gives a full period.
  task automatic test_load();
    exp_t        e;
    logic [31:0] tab [7];
    tab = '{32'h10, 32'h10, 32'h10, 32'h11, 32'h11, 32'h11, 32'h12};
    for (int i = 0; i < 7; i++) begin
      cnt_en         = 1'b1;
      pdu_aou_wen_lr = (i == 0);
      pwdata         = 32'h0000_0010;
      rtcclkdivcfg   = (i == 0) ? 20'd1 : 20'd3;
      sb.push_back('{"load", tab[i], 1'b0, 1'b0, 1'b0});
      @(posedge pclk_gate);
      #1;
      e = sb.pop_front();
      checks++;
      if ({aou_pdu_ccvr, aou_pdu_raw_intr, rtc_intr} !== {e.ccvr, e.raw, e.intr}) begin
        errors++;
        $display("FAIL %s[%0d] got ccvr=%h raw=%b intr=%b, exp ccvr=%h raw=%b intr=%b",
                 e.tag, i, aou_pdu_ccvr, aou_pdu_raw_intr, rtc_intr, e.ccvr, e.raw, e.intr);
      end else begin
        $display("ok   %s[%0d] ccvr=%h raw=%b intr=%b", e.tag, i, aou_pdu_ccvr, aou_pdu_raw_intr, rtc_intr);
      end
`ifdef RTC_AOU_ETB_MATCH_EN
      checks++;
      if (rtc_etb_match !== e.etb) begin
        errors++;
        $display("FAIL %s[%0d] etb got %b exp %b", e.tag, i, rtc_etb_match, e.etb);
      end
`endif
    end
    pdu_aou_wen_lr = 1'b0;
  endtask

  // Match at 5 with wrap: 0..5 then 0; interrupt the cycle after the tick.
  task automatic test_match_wrap();
    exp_t        e;
    logic [31:0] tab [9];
    logic [8:0]  raw_tab;
    logic [8:0]  etb_tab;
    tab     = '{32'd0, 32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd0, 32'd1, 32'd2};
    raw_tab = 9'b1_1100_0000;
    etb_tab = 9'b0_0100_0000;
    match_val    = 32'd5;
    wrap_en      = 1'b1;
    intr_en      = 1'b1;
    intr_mask    = 1'b0;
    rtcclkdivcfg = 20'd1;
    cnt_en       = 1'b1;
    for (int i = 0; i < 9; i++) begin
      pdu_aou_wen_lr = (i == 0);
      pdu_aou_eoi    = (i == 0);
      pwdata         = 32'd0;
      sb.push_back('{"match_wrap", tab[i], raw_tab[i], raw_tab[i], etb_tab[i]});
      @(posedge pclk_gate);
      #1;
      e = sb.pop_front();
      checks++;
      if ({aou_pdu_ccvr, aou_pdu_raw_intr, rtc_intr} !== {e.ccvr, e.raw, e.intr}) begin
        errors++;
        $display("FAIL %s[%0d] got ccvr=%h raw=%b intr=%b, exp ccvr=%h raw=%b intr=%b",
                 e.tag, i, aou_pdu_ccvr, aou_pdu_raw_intr, rtc_intr, e.ccvr, e.raw, e.intr);
      end else begin
        $display("ok   %s[%0d] ccvr=%h raw=%b intr=%b", e.tag, i, aou_pdu_ccvr, aou_pdu_raw_intr, rtc_intr);
      end
`ifdef RTC_AOU_ETB_MATCH_EN
      checks++;
      if (rtc_etb_match !== e.etb) begin
        errors++;
        $display("FAIL %s[%0d] etb got %b exp %b", e.tag, i, rtc_etb_match, e.etb);
      end
`endif
    end
    pdu_aou_wen_lr = 1'b0;
    pdu_aou_eoi    = 1'b0;
  endtask

  // Masked interrupt; eoi colliding with a match (set wins); lone eoi; intr_en=0.
  task automatic test_mask_eoi();
    exp_t        e;
    logic [31:0] tab [12];
    logic [11:0] raw_tab;
    logic [11:0] etb_tab;
    tab     = '{32'd3, 32'd4, 32'd5, 32'd0, 32'd1, 32'd2,
                32'd3, 32'd4, 32'd5, 32'd0, 32'd1, 32'd2};
    raw_tab = 12'b0010_0000_1111;
    etb_tab = 12'b0010_0000_1000;
    for (int i = 0; i < 12; i++) begin
      intr_mask   = (i != 11);
      pdu_aou_eoi = (i == 3) || (i == 4);
      intr_en     = (i < 10);
      sb.push_back('{"mask_eoi", tab[i], raw_tab[i], 1'b0, etb_tab[i]});
      @(posedge pclk_gate);
      #1;
      e = sb.pop_front();
      checks++;
      if ({aou_pdu_ccvr, aou_pdu_raw_intr, rtc_intr} !== {e.ccvr, e.raw, e.intr}) begin
        errors++;
        $display("FAIL %s[%0d] got ccvr=%h raw=%b intr=%b, exp ccvr=%h raw=%b intr=%b",
                 e.tag, i, aou_pdu_ccvr, aou_pdu_raw_intr, rtc_intr, e.ccvr, e.raw, e.intr);
      end else begin
        $display("ok   %s[%0d] ccvr=%h raw=%b intr=%b", e.tag, i, aou_pdu_ccvr, aou_pdu_raw_intr, rtc_intr);
      end
`ifdef RTC_AOU_ETB_MATCH_EN
      checks++;
      if (rtc_etb_match !== e.etb) begin
        errors++;
        $display("FAIL %s[%0d] etb got %b exp %b", e.tag, i, rtc_etb_match, e.etb);
      end
`endif
    end
    pdu_aou_eoi = 1'b0;
  endtask

  // No wrap: 32-bit rollover with no flag, then a match at 3 keeps counting.
  task automatic test_rollover();
    exp_t        e;
    logic [31:0] tab [8];
    logic [7:0]  raw_tab;
    logic [7:0]  etb_tab;
    tab     = '{32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'd0, 32'd1, 32'd2, 32'd3, 32'd4, 32'd5};
    raw_tab = 8'b1100_0000;
    etb_tab = 8'b0100_0000;
    wrap_en      = 1'b0;
    intr_en      = 1'b1;
    intr_mask    = 1'b0;
    match_val    = 32'd3;
    rtcclkdivcfg = 20'd1;
    for (int i = 0; i < 8; i++) begin
      pdu_aou_wen_lr = (i == 0);
      pwdata         = 32'hFFFF_FFFE;
      sb.push_back('{"rollover", tab[i], raw_tab[i], raw_tab[i], etb_tab[i]});
      @(posedge pclk_gate);
      #1;
      e = sb.pop_front();
      checks++;
      if ({aou_pdu_ccvr, aou_pdu_raw_intr, rtc_intr} !== {e.ccvr, e.raw, e.intr}) begin
        errors++;
        $display("FAIL %s[%0d] got ccvr=%h raw=%b intr=%b, exp ccvr=%h raw=%b intr=%b",
                 e.tag, i, aou_pdu_ccvr, aou_pdu_raw_intr, rtc_intr, e.ccvr, e.raw, e.intr);
      end else begin
        $display("ok   %s[%0d] ccvr=%h raw=%b intr=%b", e.tag, i, aou_pdu_ccvr, aou_pdu_raw_intr, rtc_intr);
      end
`ifdef RTC_AOU_ETB_MATCH_EN
      checks++;
      if (rtc_etb_match !== e.etb) begin
        errors++;
        $display("FAIL %s[%0d] etb got %b exp %b", e.tag, i, rtc_etb_match, e.etb);
      end
`endif
    end
    pdu_aou_wen_lr = 1'b0;
  endtask

  // Divisor 10 with prescaler at 7, lowered to 3: tick next cycle, then every 3.
  task automatic test_cfg_lower();
    exp_t        e;
    logic [31:0] tab [15];
    tab = '{32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0,
            32'd1, 32'd1, 32'd1, 32'd2, 32'd2, 32'd2, 32'd3};
    intr_en   = 1'b0;
    match_val = 32'hFFFF_0000;
    for (int i = 0; i < 15; i++) begin
      pdu_aou_wen_lr = (i == 0);
      pwdata         = 32'd0;
      rtcclkdivcfg   = (i < 8) ? 20'd10 : 20'd3;
      sb.push_back('{"cfg_lower", tab[i], 1'b0, 1'b0, 1'b0});
      @(posedge pclk_gate);
      #1;
      e = sb.pop_front();
      checks++;
      if ({aou_pdu_ccvr, aou_pdu_raw_intr, rtc_intr} !== {e.ccvr, e.raw, e.intr}) begin
        errors++;
        $display("FAIL %s[%0d] got ccvr=%h raw=%b intr=%b, exp ccvr=%h raw=%b intr=%b",
                 e.tag, i, aou_pdu_ccvr, aou_pdu_raw_intr, rtc_intr, e.ccvr, e.raw, e.intr);
      end else begin
        $display("ok   %s[%0d] ccvr=%h raw=%b intr=%b", e.tag, i, aou_pdu_ccvr, aou_pdu_raw_intr, rtc_intr);
      end
`ifdef RTC_AOU_ETB_MATCH_EN
      checks++;
      if (rtc_etb_match !== e.etb) begin
        errors++;
        $display("FAIL %s[%0d] etb got %b exp %b", e.tag, i, rtc_etb_match, e.etb);
      end
`endif
    end
    pdu_aou_wen_lr = 1'b0;
  endtask

  // Reach a live interrupt, assert reset mid-cycle (no clock edge), then
  // confirm the prescaler restarted from zero with divisor 4.
  task automatic test_async_reset();
    exp_t        e;
    logic [31:0] tab [8];
    logic [7:0]  raw_tab;
    tab     = '{32'd4, 32'd5, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd1};
    raw_tab = 8'b0000_0100;
    match_val    = 32'd5;
    wrap_en      = 1'b1;
    intr_en      = 1'b1;
    intr_mask    = 1'b0;
    rtcclkdivcfg = 20'd1;
    for (int i = 0; i < 8; i++) begin
      pdu_aou_wen_lr = (i == 0);
      pwdata         = 32'd4;
      sb.push_back('{"async_reset", tab[i], raw_tab[i], raw_tab[i], raw_tab[i]});
      if (i == 3) begin
        #3;
        presetn = 1'b0;
        #1;
      end else begin
        @(posedge pclk_gate);
        #1;
      end
      e = sb.pop_front();
      checks++;
      if ({aou_pdu_ccvr, aou_pdu_raw_intr, rtc_intr} !== {e.ccvr, e.raw, e.intr}) begin
        errors++;
        $display("FAIL %s[%0d] got ccvr=%h raw=%b intr=%b, exp ccvr=%h raw=%b intr=%b",
                 e.tag, i, aou_pdu_ccvr, aou_pdu_raw_intr, rtc_intr, e.ccvr, e.raw, e.intr);
      end else begin
        $display("ok   %s[%0d] ccvr=%h raw=%b intr=%b", e.tag, i, aou_pdu_ccvr, aou_pdu_raw_intr, rtc_intr);
      end
`ifdef RTC_AOU_ETB_MATCH_EN
      checks++;
      if (rtc_etb_match !== e.etb) begin
        errors++;
        $display("FAIL %s[%0d] etb got %b exp %b", e.tag, i, rtc_etb_match, e.etb);
      end
`endif
      if (i == 3) begin
        rtcclkdivcfg = 20'd4;
        #2;
        presetn = 1'b1;
      end
    end
    pdu_aou_wen_lr = 1'b0;
  endtask

  initial begin
    presetn        = 1'b0;
    cnt_en         = 1'b0;
    wrap_en        = 1'b0;
    intr_en        = 1'b0;
    intr_mask      = 1'b0;
    match_val      = 32'd0;
    rtcclkdivcfg   = 20'd0;
    pdu_aou_wen_lr = 1'b0;
    pwdata         = 32'd0;
    pdu_aou_eoi    = 1'b0;

    test_reset();
    test_prescale();
    test_load();
    test_match_wrap();
    test_mask_eoi();
    test_rollover();
    test_cfg_lower();
    test_async_reset();

    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain left=%0d exp 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Run-time guard in case the stimulus ever stalls.
  initial begin
    #200000;
    $display("FAIL watchdog timeout got running exp finished");
    $fatal(1, "watchdog");
  end

endmodule
